// File: rtl/ysyx_220053_divider.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU and their W forms.
// One quotient bit per cycle; divide-by-zero and signed overflow finish in one cycle.
module ysyx_220053_divider #(
    parameter int unsigned XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            div_valid,
    output logic            div_ready,
    input  logic            div_signed,
    input  logic            divw,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);
    localparam int unsigned CW = $clog2(XLEN);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] a_q, a_d, b_q, b_d, r_q, r_d;
    logic [XLEN-1:0] quotient_q, quotient_d, remainder_q, remainder_d;
    logic            divw_q, divw_d, qneg_q, qneg_d, rneg_q, rneg_d;
    logic            out_valid_q, out_valid_d;

    logic [XLEN-1:0] op_a, op_b, abs_a, abs_b, min_val, a_w_sext, spec_q, spec_r;
    logic            a_neg, b_neg, div_zero, sgn_ovf;

    always_comb begin
        a_w_sext = {{(XLEN-32){dividend[31]}}, dividend[31:0]};
        if (divw) begin
            op_a    = div_signed ? a_w_sext : {{(XLEN-32){1'b0}}, dividend[31:0]};
            op_b    = div_signed ? {{(XLEN-32){divisor[31]}}, divisor[31:0]}
                                 : {{(XLEN-32){1'b0}}, divisor[31:0]};
            min_val = {{(XLEN-31){1'b1}}, {31{1'b0}}};
        end else begin
            op_a    = dividend;
            op_b    = divisor;
            min_val = {1'b1, {(XLEN-1){1'b0}}};
        end
        a_neg    = div_signed & op_a[XLEN-1];
        b_neg    = div_signed & op_b[XLEN-1];
        abs_a    = a_neg ? ('0 - op_a) : op_a;
        abs_b    = b_neg ? ('0 - op_b) : op_b;
        div_zero = (op_b == '0);
        sgn_ovf  = div_signed && (op_a == min_val) && (op_b == '1);
        spec_q   = div_zero ? '1 : op_a;
        spec_r   = div_zero ? (divw ? a_w_sext : dividend) : '0;
    end

    // a_q shifts dividend bits out of the top while quotient bits enter at the bottom
    logic [XLEN:0]   r_sh, diff;
    logic            ge;
    logic [XLEN-1:0] a_step, r_step, q_raw, r_raw, q_fix, r_fix, q_fin, r_fin;

    always_comb begin
        r_sh   = {r_q, a_q[XLEN-1]};
        diff   = r_sh - {1'b0, b_q};
        ge     = ~diff[XLEN];
        r_step = ge ? diff[XLEN-1:0] : r_sh[XLEN-1:0];
        a_step = {a_q[XLEN-2:0], ge};
        q_raw  = divw_q ? {{(XLEN-32){1'b0}}, a_step[31:0]} : a_step;
        r_raw  = divw_q ? {{(XLEN-32){1'b0}}, r_step[31:0]} : r_step;
        q_fix  = qneg_q ? ('0 - q_raw) : q_raw;
        r_fix  = rneg_q ? ('0 - r_raw) : r_raw;
        q_fin  = divw_q ? {{(XLEN-32){q_fix[31]}}, q_fix[31:0]} : q_fix;
        r_fin  = divw_q ? {{(XLEN-32){r_fix[31]}}, r_fix[31:0]} : r_fix;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        r_d         = r_q;
        divw_d      = divw_q;
        qneg_d      = qneg_q;
        rneg_d      = rneg_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        out_valid_d = out_valid_q;
        unique case (state_q)
            S_IDLE: begin
                if (!flush && div_valid) begin
                    divw_d = divw;
                    qneg_d = a_neg ^ b_neg;
                    rneg_d = a_neg;
                    if (div_zero || sgn_ovf) begin
                        quotient_d  = spec_q;
                        remainder_d = spec_r;
                        out_valid_d = 1'b1;
                        state_d     = S_DONE;
                    end else begin
                        a_d     = divw ? {abs_a[31:0], {(XLEN-32){1'b0}}} : abs_a;
                        b_d     = abs_b;
                        r_d     = '0;
                        cnt_d   = divw ? CW'(31) : CW'(XLEN-1);
                        state_d = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    a_d = a_step;
                    r_d = r_step;
                    // sign fix-up happens on the final step so out_valid lands at N+1
                    if (cnt_q == '0) begin
                        quotient_d  = q_fin;
                        remainder_d = r_fin;
                        out_valid_d = 1'b1;
                        state_d     = S_DONE;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            S_DONE: begin
                if (flush || out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            r_q         <= '0;
            divw_q      <= 1'b0;
            qneg_q      <= 1'b0;
            rneg_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            r_q         <= r_d;
            divw_q      <= divw_d;
            qneg_q      <= qneg_d;
            rneg_q      <= rneg_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign div_ready = (state_q == S_IDLE);
    assign out_valid = out_valid_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
endmodule

// File: tb/tb_ysyx_220053_divider.sv
// Self-checking bench for ysyx_220053_divider: directed cases, random ops against
// an arithmetic reference model, backpressure, flush and mid-operation reset.
module tb_ysyx_220053_divider;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        div_valid, div_ready, div_signed, divw, flush;
    logic        out_valid, out_ready;
    logic [63:0] dividend, divisor, quotient, remainder;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    ysyx_220053_divider #(.XLEN(64)) dut (
        .clk(clk), .rst_n(rst_n), .div_valid(div_valid), .div_ready(div_ready),
        .div_signed(div_signed), .divw(divw), .dividend(dividend), .divisor(divisor),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .quotient(quotient), .remainder(remainder)
    );

    // RISC-V division semantics from plain arithmetic
    function automatic void model(input logic [63:0] a, input logic [63:0] b,
                                  input logic s, input logic w,
                                  output logic [63:0] q, output logic [63:0] r,
                                  output bit sp);
        logic [31:0] a32, b32, q32, r32;
        int          sa32, sb32;
        longint      sa, sb;
        sp = 1'b0;
        if (w) begin
            a32 = a[31:0];
            b32 = b[31:0];
            if (b32 == 32'd0) begin
                sp = 1'b1; q32 = 32'hFFFF_FFFF; r32 = a32;
            end else if (s && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
                sp = 1'b1; q32 = a32; r32 = 32'd0;
            end else if (s) begin
                sa32 = a32; sb32 = b32; q32 = sa32 / sb32; r32 = sa32 % sb32;
            end else begin
                q32 = a32 / b32; r32 = a32 % b32;
            end
            q = {{32{q32[31]}}, q32};
            r = {{32{r32[31]}}, r32};
        end else begin
            if (b == 64'd0) begin
                sp = 1'b1; q = '1; r = a;
            end else if (s && a == 64'h8000_0000_0000_0000 && b == '1) begin
                sp = 1'b1; q = a; r = 64'd0;
            end else if (s) begin
                sa = a; sb = b; q = sa / sb; r = sa % sb;
            end else begin
                q = a / b; r = a % b;
            end
        end
    endfunction

    task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic s, input logic w);
        @(negedge clk);
        dividend = a; divisor = b; div_signed = s; divw = w; div_valid = 1'b1;
        @(posedge clk);
        #1;
        div_valid = 1'b0;
        dividend = {$urandom, $urandom};
        divisor  = {$urandom, $urandom};
    endtask

    // lat counts edges from the accept edge (accept edge = 1); bounded wait
    task automatic wait_result(output int lat, output int rdy_hi);
        lat = 1;
        rdy_hi = 0;
        while (!out_valid && lat < 200) begin
            if (div_ready) rdy_hi++;
            @(posedge clk);
            #1;
            lat++;
        end
        if (div_ready) rdy_hi++;
    endtask

    task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic s, input logic w,
                          output logic [63:0] q, output logic [63:0] r, output int lat,
                          output int rdy_hi, output logic post_v, output logic post_r);
        issue(a, b, s, w);
        wait_result(lat, rdy_hi);
        q = quotient;
        r = remainder;
        @(posedge clk);
        #1;
        post_v = out_valid;
        post_r = div_ready;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; div_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        div_signed = 1'b0; divw = 1'b0; dividend = '0; divisor = '0;
        #12;
        total += 4;
        if (div_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", div_ready); end
        if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        if (quotient !== 64'd0) begin bad++; $display("FAIL reset_quot got=%h exp=0", quotient); end
        if (remainder !== 64'd0) begin bad++; $display("FAIL reset_rem got=%h exp=0", remainder); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [63:0] a, b;
        logic        s, w;
        logic [63:0] q, r;
        int          lat;
    } vec_t;

    task automatic test_directed();
        vec_t v[7];
        logic [63:0] q, r;
        int lat, rdy_hi;
        logic pv, pr;
        v[0] = '{64'd100, 64'd7, 1'b0, 1'b0, 64'd14, 64'd2, 65};
        v[1] = '{64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, 1'b0,
                 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 65};
        v[2] = '{64'h123, 64'd0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h123, 1};
        v[3] = '{64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0,
                 64'h8000_0000_0000_0000, 64'd0, 1};
        v[4] = '{64'h0000_0001_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1,
                 64'hFFFF_FFFF_8000_0000, 64'd0, 1};
        v[5] = '{64'h0000_0000_FFFF_FFFF, 64'd2, 1'b0, 1'b1, 64'h7FFF_FFFF, 64'd1, 33};
        v[6] = '{64'h1234_5678_8000_0005, 64'hABCD_0000_0000_0000, 1'b0, 1'b1,
                 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0005, 1};
        foreach (v[i]) begin
            run_op(v[i].a, v[i].b, v[i].s, v[i].w, q, r, lat, rdy_hi, pv, pr);
            total += 6;
            if (q !== v[i].q) begin bad++; $display("FAIL dir%0d_quot got=%h exp=%h", i, q, v[i].q); end
            if (r !== v[i].r) begin bad++; $display("FAIL dir%0d_rem got=%h exp=%h", i, r, v[i].r); end
            if (lat != v[i].lat) begin bad++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, v[i].lat); end
            if (rdy_hi != 0) begin bad++; $display("FAIL dir%0d_ready_busy got=%0d exp=0", i, rdy_hi); end
            if (pv !== 1'b0) begin bad++; $display("FAIL dir%0d_valid_drop got=%b exp=0", i, pv); end
            if (pr !== 1'b1) begin bad++; $display("FAIL dir%0d_ready_back got=%b exp=1", i, pr); end
        end
    endtask

    task automatic test_random();
        logic [63:0] a, b, eq, er, q, r;
        logic s, w, pv, pr;
        bit sp;
        int lat, rdy_hi, elat;
        for (int i = 0; i < 30; i++) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            s = 1'($urandom_range(0, 1));
            w = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
                0: b = w ? {b[63:32], 32'd0} : 64'd0;
                1: begin
                    s = 1'b1;
                    b = w ? {b[63:32], 32'hFFFF_FFFF} : '1;
                    a = w ? {a[63:32], 32'h8000_0000} : 64'h8000_0000_0000_0000;
                end
                2: b = 64'($urandom_range(1, 1000));
                3: b = '0 - 64'($urandom_range(1, 1000));
                default: ;
            endcase
            model(a, b, s, w, eq, er, sp);
            elat = sp ? 1 : (w ? 33 : 65);
            run_op(a, b, s, w, q, r, lat, rdy_hi, pv, pr);
            total += 3;
            if (q !== eq) begin bad++; $display("FAIL rnd%0d_quot a=%h b=%h s=%b w=%b got=%h exp=%h", i, a, b, s, w, q, eq); end
            if (r !== er) begin bad++; $display("FAIL rnd%0d_rem a=%h b=%h s=%b w=%b got=%h exp=%h", i, a, b, s, w, r, er); end
            if (lat != elat) begin bad++; $display("FAIL rnd%0d_latency got=%0d exp=%0d", i, lat, elat); end
        end
    endtask

    task automatic test_backpressure();
        int lat, rdy_hi;
        out_ready = 1'b0;
        issue(64'd1000, 64'd33, 1'b0, 1'b0);
        wait_result(lat, rdy_hi);
        total++;
        if (lat != 65) begin bad++; $display("FAIL bp_latency got=%0d exp=65", lat); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            total += 4;
            if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_hold_valid%0d got=%b exp=1", i, out_valid); end
            if (quotient !== 64'd30) begin bad++; $display("FAIL bp_hold_quot%0d got=%h exp=1e", i, quotient); end
            if (remainder !== 64'd10) begin bad++; $display("FAIL bp_hold_rem%0d got=%h exp=a", i, remainder); end
            if (div_ready !== 1'b0) begin bad++; $display("FAIL bp_hold_ready%0d got=%b exp=0", i, div_ready); end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        total += 2;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_release_valid got=%b exp=0", out_valid); end
        if (div_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%b exp=1", div_ready); end
        // flush while a result is held discards it
        out_ready = 1'b0;
        issue(64'h55, 64'd0, 1'b0, 1'b0);
        wait_result(lat, rdy_hi);
        total++;
        if (lat != 1) begin bad++; $display("FAIL bp_dz_latency got=%0d exp=1", lat); end
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        out_ready = 1'b1;
        total += 2;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL done_flush_valid got=%b exp=0", out_valid); end
        if (div_ready !== 1'b1) begin bad++; $display("FAIL done_flush_ready got=%b exp=1", div_ready); end
    endtask

    task automatic test_flush();
        logic [63:0] q, r, eq, er;
        logic pv, pr;
        bit sp;
        int lat, rdy_hi, seen;
        issue(64'd12345, 64'd67, 1'b0, 1'b0);
        for (int i = 1; i < 10; i++) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        total += 2;
        if (div_ready !== 1'b1) begin bad++; $display("FAIL busy_flush_ready got=%b exp=1", div_ready); end
        if (out_valid !== 1'b0) begin bad++; $display("FAIL busy_flush_valid got=%b exp=0", out_valid); end
        seen = 0;
        for (int i = 0; i < 70; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        total++;
        if (seen != 0) begin bad++; $display("FAIL busy_flush_ghost got=%0d exp=0", seen); end
        // flush wins over a request in IDLE
        @(negedge clk);
        dividend = 64'h77; divisor = 64'd0; div_signed = 1'b0; divw = 1'b0;
        div_valid = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1;
        div_valid = 1'b0; flush = 1'b0;
        total += 2;
        if (div_ready !== 1'b1) begin bad++; $display("FAIL idle_flush_ready got=%b exp=1", div_ready); end
        if (out_valid !== 1'b0) begin bad++; $display("FAIL idle_flush_valid got=%b exp=0", out_valid); end
        model(64'hFFFF_FFFF_FFFF_D000, 64'd13, 1'b1, 1'b0, eq, er, sp);
        run_op(64'hFFFF_FFFF_FFFF_D000, 64'd13, 1'b1, 1'b0, q, r, lat, rdy_hi, pv, pr);
        total += 3;
        if (q !== eq) begin bad++; $display("FAIL post_flush_quot got=%h exp=%h", q, eq); end
        if (r !== er) begin bad++; $display("FAIL post_flush_rem got=%h exp=%h", r, er); end
        if (lat != 65) begin bad++; $display("FAIL post_flush_latency got=%0d exp=65", lat); end
    endtask

    task automatic test_midop_reset();
        issue(64'd900, 64'd11, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        total += 3;
        if (div_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready got=%b exp=1", div_ready); end
        if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%b exp=0", out_valid); end
        if (quotient !== 64'd0) begin bad++; $display("FAIL midrst_quot got=%h exp=0", quotient); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_flush();
        test_midop_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
